// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master and its users.
// Contents: FSM state type, default bus widths, UART register word offsets
// (word addresses, i.e. the value driven on PADDR[11:2]).
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned APB_ADDR_W = 10;
  localparam int unsigned APB_DATA_W = 16;

  localparam logic [APB_ADDR_W-1:0] UART_DR    = 10'h000;
  localparam logic [APB_ADDR_W-1:0] UART_RSR   = 10'h001;
  localparam logic [APB_ADDR_W-1:0] UART_FR    = 10'h006;
  localparam logic [APB_ADDR_W-1:0] UART_IBRD  = 10'h009;
  localparam logic [APB_ADDR_W-1:0] UART_FBRD  = 10'h00A;
  localparam logic [APB_ADDR_W-1:0] UART_LCR_H = 10'h00B;
  localparam logic [APB_ADDR_W-1:0] UART_CR    = 10'h00C;
  localparam logic [APB_ADDR_W-1:0] UART_IFLS  = 10'h00D;
  localparam logic [APB_ADDR_W-1:0] UART_IMSC  = 10'h00E;
  localparam logic [APB_ADDR_W-1:0] UART_RIS   = 10'h00F;
  localparam logic [APB_ADDR_W-1:0] UART_MIS   = 10'h010;
  localparam logic [APB_ADDR_W-1:0] UART_ICR   = 10'h011;
  localparam logic [APB_ADDR_W-1:0] UART_DMACR = 10'h012;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase.
// Ports: PCLK/PRESETn clock and async active-low reset; clear zeroes the
// count; enable advances it by one (saturating); expire is high while the
// count sits on the last allowed wait cycle (never when TIMEOUT is 0).
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // TIMEOUT=0 would give a zero-width counter; keep one harmless bit.
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 initiator: converts a valid/ready command stream into single APB
// transfers and returns read data / error on a valid/ready response channel.
// Ports:
//   PCLK, PRESETn           clock, async active-low reset
//   cmd_valid/ready, cmd_write, cmd_addr, cmd_wdata   command channel
//   rsp_valid/ready, rsp_rdata, rsp_err               response channel
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA              APB request (all flops)
//   PRDATA, PREADY, PSLVERR                           APB completion
// A completer holding PREADY low for TIMEOUT ACCESS cycles is abandoned and
// reported with rsp_err=1; TIMEOUT=0 waits forever.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e state, state_nx;
  logic       tmo_expire;

  // Held in clear outside ACCESS, so the count is zero on every ACCESS entry.
  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .clear  (state != ACCESS),
    .enable (state == ACCESS && !PREADY),
    .expire (tmo_expire)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (PREADY || tmo_expire) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);

  // Bus strobes and rsp_valid are registered from the next state so every
  // APB output leaves a flop with no decode behind it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      PSEL      <= (state_nx == SETUP) || (state_nx == ACCESS);
      PENABLE   <= (state_nx == ACCESS);
      rsp_valid <= (state_nx == RESP);

      if (state == IDLE && cmd_valid) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end

      if (state == ACCESS) begin
        if (PREADY) begin
          rsp_rdata <= PWRITE ? '0 : PRDATA;
          rsp_err   <= PSLVERR;
        end else if (tmo_expire) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
Synthesizable APB initiator that turns a simple valid/ready command stream into single APB3 transfers. It returns read data and an error flag on a valid/ready response channel. It sits between an on-chip controller (or the bench's UART bring-up sequencer) and the 16-bit APB UART register bank at word addresses PADDR[11:2]. It supports PREADY wait states, PSLVERR, and a bounded wait timeout so a hung completer cannot stall the controller.

Parameters:
ADDR_W, 10, word-address width (maps to PADDR[11:2])
DATA_W, 16, APB data width
TIMEOUT, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables the timeout

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a PCLK rising edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  word address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at an edge
rsp_rdata  out  DATA_W  read data (0 for writes and aborts)
rsp_err  out  1  PSLVERR seen or timeout abort
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB word address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  completer ready; tie 1 for zero-wait completers
PSLVERR  in  1  completer error, sampled only with PREADY

Behaviour:
- Reset is PRESETn, asynchronous, active-low; the clock is PCLK. All flops are on the PCLK rising edge.
- Reset values: state=IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA=0; rsp_valid, rsp_err=0; rsp_rdata=0; wait counter=0. cmd_ready=1 as soon as reset is released.
- All APB outputs come directly from flops; there is no combinational path from the cmd_* inputs to the APB outputs.
- FSM state IDLE:
  - cmd_ready=1.
  - On handshake, latch cmd_write, cmd_addr and cmd_wdata into PWRITE/PADDR/PWDATA and go to SETUP.
  - cmd_* may change after the handshake edge.
- FSM state SETUP:
  - PSEL=1, PENABLE=0.
  - Unconditionally go to ACCESS after 1 cycle.
- FSM state ACCESS:
  - PSEL=1, PENABLE=1; wait counter cleared on entry.
  - PREADY=1: capture PRDATA into rsp_rdata (reads only; writes load 0), rsp_err<=PSLVERR, go to RESP.
  - PREADY=0 and TIMEOUT!=0 and counter==TIMEOUT-1: abort. rsp_err<=1, rsp_rdata<=0, go to RESP.
  - Otherwise increment the counter and stay in ACCESS.
  - If PREADY=1 arrives on the final allowed cycle, completion wins over abort.
- FSM state RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1, cmd_ready=0.
  - rsp_rdata and rsp_err are held stable until the handshake.
  - On rsp_valid & rsp_ready, go to IDLE and clear rsp_valid.
- PADDR, PWRITE and PWDATA hold their last value outside transfers; they never return to 0 except on reset.
- PADDR, PWRITE and PWDATA are stable from SETUP through the final ACCESS cycle, including across wait states.
- Latency with zero wait states:
  - Handshake edge E.
  - PSEL=1 after E.
  - PENABLE=1 after E+1.
  - rsp_valid=1 after E+2.
  - cmd_ready=1 again one cycle after the rsp handshake.
  - Maximum throughput is 1 transfer per 4 cycles.
- No pipelining: exactly one outstanding command, and no new PSEL while rsp_valid=1.
- Wait-counter width is clog2(TIMEOUT+1); it saturates harmlessly when TIMEOUT=0.
- Reset during an active transfer: PSEL and PENABLE drop immediately (asynchronous); any pending response is discarded.
- PRDATA and PSLVERR are ignored whenever the FSM is not in ACCESS with PREADY=1.

Decomposition:
- Shared package apb_pkg holds:
  - The FSM state enum {IDLE, SETUP, ACCESS, RESP}.
  - Default ADDR_W/DATA_W constants.
  - UART word-offset constants: DR 0x000, RSR 0x001, FR 0x006, IBRD 0x009, FBRD 0x00A, LCR_H 0x00B, CR 0x00C, IFLS 0x00D, IMSC 0x00E, RIS 0x00F, MIS 0x010, ICR 0x011, DMACR 0x012.
- Single module. The wait/timeout counter may optionally be split out as apb_wait_timer (clear, enable, expire); the module is otherwise flat.

Test Plan:
1. Zero-wait write: write IBRD (0x009) = 0x0027 with PREADY=1.
   -> PSEL 1 cycle after the handshake, PENABLE the next cycle, PWDATA=0x0027, rsp_valid at E+2, rsp_err=0, rsp_rdata=0.
2. Zero-wait read: read CR (0x00C) with the completer driving 0x0300.
   -> rsp_rdata=0x0300, rsp_err=0; a following read of IFLS (0x00D) returns 0x0012.
3. Wait states: PREADY low for 3 ACCESS cycles on a read of FR (0x006) = 0x0980.
   -> PENABLE high exactly 4 cycles, PADDR stable at 0x006, rsp_rdata=0x0980.
4. Timeout: PREADY stuck 0, TIMEOUT=16.
   -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
   -> Repeat with PREADY=1 on the 16th cycle: normal completion, rsp_err=0.
5. PSLVERR=1 with PREADY=1 on a write to ICR (0x011).
   -> rsp_err=1. The next command is accepted and completes with rsp_err=0.
6. Backpressure and reset:
   -> Hold rsp_ready=0 for 5 cycles: rsp_valid, rsp_rdata and rsp_err are stable, cmd_ready=0, PSEL=0 throughout.
   -> Assert PRESETn=0 mid-ACCESS: PSEL, PENABLE and rsp_valid go to 0 without waiting for a PCLK edge, and the FSM is in IDLE after release.
